data_bus_arbiter: RTL and testbench

//  Shares the single data-memory bus (RAM / plugin / RTC / PLIC / TB regions) between two masters:
//  M0 = RS5 data port, M1 = plugin DMA master. Round-robin arbitration with an atomic-lock option.

---
 rtl/data_bus_arbiter_pkg.sv | 38 +++
 rtl/data_bus_region_decode.sv | 38 +++
 rtl/data_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
// Region order matches the bit order of the one-hot slave enable {TB,PLIC,RTC,PLUGIN,RAM}.
package data_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    REG_RAM    = 3'd0,
    REG_PLUGIN = 3'd1,
    REG_RTC    = 3'd2,
    REG_PLIC   = 3'd3,
    REG_TB     = 3'd4
  } region_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // First address nibble of each region; anything below NIB_PLUGIN is RAM.
  localparam logic [3:0] NIB_PLUGIN = 4'h1;
  localparam logic [3:0] NIB_RTC    = 4'h2;
  localparam logic [3:0] NIB_PLIC   = 4'h3;
  localparam logic [3:0] NIB_TB     = 4'h8;

  function automatic logic [4:0] region_onehot(input region_e region);
    logic [4:0] en;
    case (region)
      REG_RAM:    en = 5'b00001;
      REG_PLUGIN: en = 5'b00010;
      REG_RTC:    en = 5'b00100;
      REG_PLIC:   en = 5'b01000;
      REG_TB:     en = 5'b10000;
      default:    en = 5'b00000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/data_bus_region_decode.sv
// Combinational address decode: addr[31:28] -> region and one-hot slave enable.
// The enable stays all-zero unless a grant is being issued this cycle.
module data_bus_region_decode
  import data_bus_arbiter_pkg::*;
(
  input  logic [31:0] addr,
  input  logic        valid,
  output region_e     region,
  output logic [4:0]  en
);

  logic [3:0] nib;

  assign nib = addr[31:28];

  // Nibble range compare, lowest region first
  always_comb begin
    region = REG_TB;
    en     = 5'b00000;
    if (nib < NIB_PLUGIN) begin
      region = REG_RAM;
    end else if (nib < NIB_RTC) begin
      region = REG_PLUGIN;
    end else if (nib < NIB_PLIC) begin
      region = REG_RTC;
    end else if (nib < NIB_TB) begin
      region = REG_PLIC;
    end else begin
      region = REG_TB;
    end
    if (valid) begin
      en = region_onehot(region);
    end else begin
      en = 5'b00000;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data-bus arbiter: round-robin with bounded atomic lock, same-cycle grant,
// one-cycle read return steered by the registered owner/region, saturating wait counters.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 16,
  parameter int WAIT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             m_req_i,
  input  logic [1:0]             m_lock_i,
  input  logic [1:0][3:0]        m_we_i,
  input  logic [1:0][31:0]       m_addr_i,
  input  logic [1:0][31:0]       m_wdata_i,
  output logic [1:0]             m_gnt_o,
  output logic [1:0]             m_rvalid_o,
  output logic [31:0]            m_rdata_o,
  output logic                   stall_o,
  output logic [4:0]             s_en_o,
  output logic [3:0]             s_we_o,
  output logic [31:0]            s_addr_o,
  output logic [31:0]            s_wdata_o,
  input  logic [4:0][31:0]       s_rdata_i,
  output logic [1:0][WAIT_W-1:0] wait_cnt_o
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e             state_r, state_s;
  logic                   rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0]       lock_cnt_r, lock_cnt_s;
  logic                   own_idx_s;
  logic                   gnt_any_s;
  logic                   win_s;
  logic [1:0]             gnt_int_s;
  region_e                win_region_s;
  logic [4:0]             en_s;
  logic                   rd_pend_r;
  logic                   rd_owner_r;
  region_e                rd_region_r;
  logic [1:0][WAIT_W-1:0] wait_cnt_r;

  assign own_idx_s = (state_r == ARB_OWN1);

  // Arbitration: lock owner keeps the bus while it qualifies, otherwise round-robin
  always_comb begin
    state_s    = state_r;
    rr_ptr_s   = rr_ptr_r;
    lock_cnt_s = lock_cnt_r;
    gnt_any_s  = 1'b0;
    win_s      = 1'b0;
    if ((state_r != ARB_IDLE) && m_req_i[own_idx_s] && m_lock_i[own_idx_s] &&
        (lock_cnt_r < CNT_W'(LOCK_MAX))) begin
      gnt_any_s  = 1'b1;
      win_s      = own_idx_s;
      lock_cnt_s = lock_cnt_r + CNT_W'(1);
    end else begin
      // Lock dropped, owner idle or lock budget spent: fall back to normal arbitration now
      state_s    = ARB_IDLE;
      lock_cnt_s = CNT_W'(0);
      if (m_req_i != 2'b00) begin
        gnt_any_s = 1'b1;
        if (m_req_i == 2'b11) begin
          win_s = rr_ptr_r;
        end else begin
          win_s = m_req_i[1];
        end
        rr_ptr_s = ~win_s;
        if (m_lock_i[win_s]) begin
          state_s    = win_s ? ARB_OWN1 : ARB_OWN0;
          lock_cnt_s = CNT_W'(1);
        end else begin
          state_s = ARB_IDLE;
        end
      end else begin
        gnt_any_s = 1'b0;
      end
    end
  end

  assign gnt_int_s = gnt_any_s ? (win_s ? 2'b10 : 2'b01) : 2'b00;

  data_bus_region_decode u_decode (
    .addr   (m_addr_i[win_s]),
    .valid  (gnt_any_s),
    .region (win_region_s),
    .en     (en_s)
  );

  // Bus-side outputs; reset forces them quiet even while masters keep requesting
  always_comb begin
    m_gnt_o   = 2'b00;
    stall_o   = 1'b0;
    s_en_o    = 5'b00000;
    s_we_o    = 4'h0;
    s_addr_o  = 32'h0000_0000;
    s_wdata_o = 32'h0000_0000;
    if (!reset && gnt_any_s) begin
      m_gnt_o   = gnt_int_s;
      s_en_o    = en_s;
      s_we_o    = m_we_i[win_s];
      s_addr_o  = m_addr_i[win_s];
      s_wdata_o = m_wdata_i[win_s];
    end else begin
      m_gnt_o = 2'b00;
    end
    stall_o = !reset && m_req_i[0] && !m_gnt_o[0];
  end

  // Read return path, steered by the registered owner and region
  always_comb begin
    m_rvalid_o = 2'b00;
    m_rdata_o  = 32'h0000_0000;
    if (rd_pend_r) begin
      m_rvalid_o = rd_owner_r ? 2'b10 : 2'b01;
      m_rdata_o  = s_rdata_i[rd_region_r];
    end else begin
      m_rvalid_o = 2'b00;
    end
  end

  assign wait_cnt_o = wait_cnt_r;

  // Arbiter state, round-robin pointer and lock counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ARB_IDLE;
      rr_ptr_r   <= 1'b0;
      lock_cnt_r <= CNT_W'(0);
    end else begin
      state_r    <= state_s;
      rr_ptr_r   <= rr_ptr_s;
      lock_cnt_r <= lock_cnt_s;
    end
  end

  // Capture {owner, region, is_read} of the granted access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_r   <= 1'b0;
      rd_owner_r  <= 1'b0;
      rd_region_r <= REG_RAM;
    end else begin
      rd_pend_r <= gnt_any_s && (m_we_i[win_s] == 4'h0);
      if (gnt_any_s) begin
        rd_owner_r  <= win_s;
        rd_region_r <= win_region_s;
      end
    end
  end

  // Saturating wait-cycle counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_req_i[i] && !gnt_int_s[i] && (wait_cnt_r[i] != {WAIT_W{1'b1}})) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + WAIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: per-scenario tasks with inline checks,
// plus a read-return scoreboard fed at grant time and drained when rvalid appears.
module tb_data_bus_arbiter;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        req, lock;
  logic [1:0][3:0]   we;
  logic [1:0][31:0]  addr, wdata;
  logic [1:0]        gnt, rvalid;
  logic [31:0]       rdata;
  logic              stall;
  logic [4:0]        s_en;
  logic [3:0]        s_we;
  logic [31:0]       s_addr, s_wdata;
  logic [4:0][31:0]  s_rdata;
  logic [1:0][3:0]   wait_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t exp_q[$];

  data_bus_arbiter #(.LOCK_MAX(16), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset),
    .m_req_i(req), .m_lock_i(lock), .m_we_i(we), .m_addr_i(addr), .m_wdata_i(wdata),
    .m_gnt_o(gnt), .m_rvalid_o(rvalid), .m_rdata_o(rdata), .stall_o(stall),
    .s_en_o(s_en), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_rdata_i(s_rdata), .wait_cnt_o(wait_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Region read data changes every cycle so late or early sampling is visible
  function automatic logic [31:0] rd_model(input int r, input int c);
    return {8'(r + 1), 8'h5A, 16'(c)};
  endfunction

  function automatic int exp_region(input logic [31:0] a);
    if (a[31:28] < 4'h1) return 0;
    else if (a[31:28] < 4'h2) return 1;
    else if (a[31:28] < 4'h3) return 2;
    else if (a[31:28] < 4'h8) return 3;
    else return 4;
  endfunction

  always_comb begin
    for (int r = 0; r < 5; r++) s_rdata[r] = rd_model(r, cyc);
  end

  task automatic push_exp(input logic [1:0] v, input logic [31:0] d);
    rd_exp_t e;
    e.valid = v;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_idle();
    req = 2'b00; lock = 2'b00; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Scoreboard: every rvalid must match the oldest expected read
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rvalid != 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected rvalid=%b rdata=%h expected no read", rvalid, rdata);
        end else begin
          e = exp_q.pop_front();
          if (rvalid !== e.valid || rdata !== e.data) begin
            errors++;
            $display("FAIL sb_read rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                     rvalid, rdata, e.valid, e.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    #2;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b exp 00", gnt); end
    checks++; if (rvalid !== 2'b00 || rdata !== 32'h0) begin errors++; $display("FAIL rst_rd got %b/%h exp 00/0", rvalid, rdata); end
    checks++; if (s_en !== 5'b0 || s_we !== 4'h0) begin errors++; $display("FAIL rst_s got en=%b we=%h exp 0", s_en, s_we); end
    checks++; if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin errors++; $display("FAIL rst_sdata got %h/%h exp 0", s_addr, s_wdata); end
    checks++; if (stall !== 1'b0 || wait_cnt !== 8'h00) begin errors++; $display("FAIL rst_misc got stall=%b wait=%h exp 0", stall, wait_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    req = 2'b01; addr[0] = 32'h0000_0010; we[0] = 4'h0;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL t1_gnt got %b exp 01", gnt); end
    checks++; if (s_en !== 5'b00001) begin errors++; $display("FAIL t1_sen got %b exp 00001", s_en); end
    checks++; if (s_addr !== 32'h0000_0010 || stall !== 1'b0) begin errors++; $display("FAIL t1_addr got %h/%b exp 00000010/0", s_addr, stall); end
    push_exp(2'b01, rd_model(0, cyc + 1));
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL t1_rvalid got %b exp 01", rvalid); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL t1_idle_gnt got %b exp 00", gnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    logic [31:0] tbl [7] = '{32'h0FFF_FFFC, 32'h1000_0000, 32'h2FFF_FFFC, 32'h3000_0000,
                             32'h7FFF_FFFC, 32'h8000_0000, 32'hFFFF_FFFC};
    logic [4:0]  exp_en;
    for (int i = 0; i < 7; i++) begin
      req = 2'b10; addr[1] = tbl[i]; we[1] = 4'h0;
      exp_en = 5'b00001 << exp_region(tbl[i]);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b10 || s_en !== exp_en) begin
        errors++; $display("FAIL dec_%0d got gnt=%b en=%b exp gnt=10 en=%b", i, gnt, s_en, exp_en);
      end
      push_exp(2'b10, rd_model(exp_region(tbl[i]), cyc + 1));
      @(posedge clk); #1;
    end
    req = 2'b00;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      req = 2'b11; we = '0;
      addr[0] = 32'h0000_0100; addr[1] = 32'h1000_0200;
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt_%0d got %b exp %b", k, gnt, exp_g); end
      checks++; if (stall !== exp_g[1]) begin errors++; $display("FAIL rr_stall_%0d got %b exp %b", k, stall, exp_g[1]); end
      checks++;
      if (wait_cnt[0] !== 4'(k / 2) || wait_cnt[1] !== 4'((k + 1) / 2)) begin
        errors++; $display("FAIL rr_wait_%0d got %0d/%0d exp %0d/%0d", k, wait_cnt[0], wait_cnt[1], k / 2, (k + 1) / 2);
      end
      push_exp(exp_g, rd_model(exp_g[1] ? 1 : 0, cyc + 1));
      @(posedge clk); #1;
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (wait_cnt[0] !== 4'd4 || wait_cnt[1] !== 4'd4) begin errors++; $display("FAIL rr_wait_end got %0d/%0d exp 4/4", wait_cnt[0], wait_cnt[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    logic [1:0] exp_g;
    apply_reset();
    for (int k = 1; k <= 34; k++) begin
      req  = (k == 1) ? 2'b10 : 2'b11;
      lock = 2'b10; we = '0;
      addr[0] = 32'h0000_0020; addr[1] = 32'h2000_0008;
      exp_g = (k == 17 || k == 34) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL lock_gnt_%0d got %b exp %b", k, gnt, exp_g); end
      checks++; if (stall !== (req[0] & ~exp_g[0])) begin errors++; $display("FAIL lock_stall_%0d got %b exp %b", k, stall, req[0] & ~exp_g[0]); end
      if (k == 17) begin
        checks++; if (wait_cnt[0] !== 4'd15) begin errors++; $display("FAIL lock_wait17 got %0d exp 15", wait_cnt[0]); end
      end
      push_exp(exp_g, rd_model(exp_g[1] ? 2 : 0, cyc + 1));
      @(posedge clk); #1;
    end
    req = 2'b00; lock = 2'b00;
    @(negedge clk);
    checks++; if (wait_cnt[0] !== 4'd15) begin errors++; $display("FAIL lock_wait_sat got %0d exp 15", wait_cnt[0]); end
    checks++; if (wait_cnt[1] !== 4'd2) begin errors++; $display("FAIL lock_wait1 got %0d exp 2", wait_cnt[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_both_lock();
    logic [1:0] exp_g;
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      req = 2'b11; we[0] = 4'hF; we[1] = 4'hF;
      lock = (k >= 4) ? 2'b10 : 2'b11;
      addr[0] = 32'h3000_0000; addr[1] = 32'h3000_0004;
      wdata[0] = 32'h0000_AAAA; wdata[1] = 32'h0000_BBBB;
      exp_g = (k >= 4) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL blk_gnt_%0d got %b exp %b", k, gnt, exp_g); end
      checks++;
      if (s_wdata !== (exp_g[1] ? 32'h0000_BBBB : 32'h0000_AAAA) || s_we !== 4'hF || s_en !== 5'b01000) begin
        errors++; $display("FAIL blk_bus_%0d got wd=%h we=%h en=%b", k, s_wdata, s_we, s_en);
      end
      @(posedge clk); #1;
    end
    drive_idle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    req = 2'b01; we = '0; addr[0] = 32'h1000_0000;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_gnt0 got %b exp 01", gnt); end
    push_exp(2'b01, rd_model(1, cyc + 1));
    @(posedge clk); #1;
    req = 2'b10; addr[1] = 32'h2000_0004;
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL b2b_gnt1 got %b exp 10", gnt); end
    checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL b2b_rv0 got %b exp 01", rvalid); end
    push_exp(2'b10, rd_model(2, cyc + 1));
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL b2b_rv1 got %b exp 10", rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    req = 2'b01; we[0] = 4'hF; addr[0] = 32'h8000_0000; wdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (gnt !== 2'b01 || stall !== 1'b0) begin errors++; $display("FAIL wr_gnt got %b/%b exp 01/0", gnt, stall); end
    checks++; if (s_en !== 5'b10000 || s_we !== 4'hF) begin errors++; $display("FAIL wr_sel got en=%b we=%h exp 10000/F", s_en, s_we); end
    checks++; if (s_wdata !== 32'hCAFE_F00D || s_addr !== 32'h8000_0000) begin errors++; $display("FAIL wr_data got %h/%h", s_wdata, s_addr); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL wr_norv got %b exp 00", rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 2'b10; lock = 2'b10; we = '0; addr[1] = 32'h0000_0040;
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rm_gnt1 got %b exp 10", gnt); end
    push_exp(2'b10, rd_model(0, cyc + 1));
    @(posedge clk); #1;
    req = 2'b11; addr[0] = 32'h0000_0080;
    @(negedge clk);
    checks++; if (gnt !== 2'b10 || stall !== 1'b1) begin errors++; $display("FAIL rm_gnt2 got %b/%b exp 10/1", gnt, stall); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (gnt !== 2'b00 || stall !== 1'b0) begin errors++; $display("FAIL rm_gnt_rst got %b/%b exp 00/0", gnt, stall); end
    checks++; if (rvalid !== 2'b00 || rdata !== 32'h0) begin errors++; $display("FAIL rm_rd_rst got %b/%h exp 00/0", rvalid, rdata); end
    checks++; if (s_en !== 5'b0 || s_addr !== 32'h0 || s_we !== 4'h0 || s_wdata !== 32'h0) begin errors++; $display("FAIL rm_s_rst got en=%b addr=%h", s_en, s_addr); end
    checks++; if (wait_cnt !== 8'h00) begin errors++; $display("FAIL rm_wait_rst got %h exp 00", wait_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_queue got %0d exp 0", exp_q.size()); end
    @(posedge clk); #1;
    reset = 1'b0; drive_idle();
    @(negedge clk);
    checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rm_norv got %b exp 00", rvalid); end
    @(posedge clk); #1;
    req = 2'b11; lock = 2'b00; we[0] = 4'hF; we[1] = 4'hF;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rm_rearb got %b exp 01", gnt); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_read();
    test_decode();
    test_round_robin();
    test_lock();
    test_both_lock();
    test_back_to_back();
    test_write();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d pending reads exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
